// File: rtl/mem_stage_dport_if.sv
// rtl/mem_stage_dport_if.sv - data-cache port bundle between MEM stage and cache
interface mem_stage_dport_if;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_mbe;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_resp;

  modport master (
    output data_read, data_write, data_addr, data_mbe, data_wdata,
    input  data_rdata, data_resp
  );

  modport slave (
    input  data_read, data_write, data_addr, data_mbe, data_wdata,
    output data_rdata, data_resp
  );
endinterface

// File: rtl/mem_stage_dport.sv
// rtl/mem_stage_dport.sv - MEM-stage data-port controller with alignment and watchdog
module mem_stage_dport #(
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_read,
  input  logic                     req_write,
  input  logic [2:0]               funct3,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic                     ext_stall,
  mem_stage_dport_if.master        dbus,
  output logic                     mem_stall,
  output logic [31:0]              load_data,
  output logic [3:0]               mem_rmask,
  output logic                     misalign,
  output logic                     illegal,
  output logic                     timeout_err
);

  localparam int CW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state, state_nxt;
  logic          access, bad_f3, mis, issue;
  logic [3:0]    mask_in;
  logic          dr, dw;
  logic [31:0]   daddr, dwdata;
  logic [3:0]    dmbe;
  logic          lat_read, lat_write;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_off;
  logic [31:0]   lat_addr, lat_wdata;
  logic [3:0]    lat_mbe;
  logic [CW-1:0] wait_cnt;

  // Shift the returned word down to the accessed byte lane and extend it.
  function automatic logic [31:0] align_load(input logic [31:0] rd, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  assign access = req_read | req_write;

  // Decode size into a byte mask and classify illegal / misaligned requests.
  always_comb begin
    mask_in = 4'b0000;
    mis     = 1'b0;
    case (funct3[1:0])
      2'b00:   mask_in = 4'b0001 << addr[1:0];
      2'b01: begin
        mask_in = 4'b0011 << addr[1:0];
        mis     = addr[0];
      end
      2'b10: begin
        mask_in = 4'b1111;
        mis     = |addr[1:0];
      end
      default: mask_in = 4'b0000;
    endcase
    bad_f3 = 1'b0;
    if (req_read && req_write)
      bad_f3 = 1'b1;
    else if (req_read)
      bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    else if (req_write)
      bad_f3 = funct3[2] || (funct3 == 3'b011);
  end

  // Next-state and cache-port drive; IDLE drives live inputs, BUSY replays the latched request.
  always_comb begin
    state_nxt = state;
    dr        = 1'b0;
    dw        = 1'b0;
    daddr     = 32'h0;
    dmbe      = 4'b0000;
    dwdata    = 32'h0;
    mem_stall = 1'b0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          if (bad_f3) begin
            illegal = 1'b1;
          end else if (mis) begin
            misalign = 1'b1;
          end else begin
            issue     = 1'b1;
            dr        = req_read;
            dw        = req_write;
            daddr     = {addr[31:2], 2'b00};
            dmbe      = mask_in;
            dwdata    = wdata << {addr[1:0], 3'b000};
            mem_stall = 1'b1;
            state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        dr        = lat_read;
        dw        = lat_write;
        daddr     = lat_addr;
        dmbe      = lat_mbe;
        dwdata    = lat_wdata;
        mem_stall = 1'b1;
        if (dbus.data_resp) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!ext_stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dbus.data_read  = dr;
  assign dbus.data_write = dw;
  assign dbus.data_addr  = daddr;
  assign dbus.data_mbe   = dmbe;
  assign dbus.data_wdata = dwdata;
  assign mem_rmask       = dr ? dmbe : 4'b0000;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Capture the issued request so the cache sees stable signals while BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_f3    <= 3'b000;
      lat_off   <= 2'b00;
      lat_addr  <= 32'h0;
      lat_mbe   <= 4'b0000;
      lat_wdata <= 32'h0;
    end else if (issue) begin
      lat_read  <= dr;
      lat_write <= dw;
      lat_f3    <= funct3;
      lat_off   <= addr[1:0];
      lat_addr  <= daddr;
      lat_mbe   <= dmbe;
      lat_wdata <= dwdata;
    end
  end

  // Response watchdog and load-result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      load_data   <= 32'h0;
    end else begin
      if (issue) begin
        wait_cnt <= '0;
      end else if (state == S_BUSY && !dbus.data_resp && RESP_TIMEOUT != 0) begin
        if (32'(wait_cnt) < RESP_TIMEOUT) wait_cnt <= wait_cnt + CW'(1);
        if (32'(wait_cnt) == RESP_TIMEOUT - 1) timeout_err <= 1'b1;
      end
      if (state == S_BUSY && dbus.data_resp && lat_read)
        load_data <= align_load(dbus.data_rdata, lat_f3, lat_off);
    end
  end

endmodule

// File: tb/tb_mem_stage_dport.sv
// tb/tb_mem_stage_dport.sv - directed self-checking bench for mem_stage_dport
module tb_mem_stage_dport;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read, req_write, ext_stall;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        mem_stall, misalign, illegal, timeout_err;
  logic [31:0] load_data;
  logic [3:0]  mem_rmask;
  int          nchk = 0;
  int          npass = 0;

  mem_stage_dport_if dif();

  mem_stage_dport #(.RESP_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .ext_stall(ext_stall),
    .dbus(dif.master), .mem_stall(mem_stall), .load_data(load_data),
    .mem_rmask(mem_rmask), .misalign(misalign), .illegal(illegal),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one access, respond on the nbusy-th BUSY cycle, stop in DONE.
  task automatic access(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int nbusy, output int stalls, output logic [31:0] o_addr,
                        output logic [3:0] o_mbe, output logic [31:0] o_wdata,
                        output logic [3:0] o_rmask, output logic hold_ok);
    req_read = r; req_write = w; funct3 = f3; addr = a; wdata = wd;
    #1;
    stalls  = int'(mem_stall);
    o_addr  = dif.data_addr;
    o_mbe   = dif.data_mbe;
    o_wdata = dif.data_wdata;
    o_rmask = mem_rmask;
    hold_ok = 1'b1;
    for (int i = 1; i <= nbusy; i++) begin
      tick();
      dif.data_resp  = (i == nbusy);
      dif.data_rdata = (i == nbusy) ? rd : 32'h0;
      #1;
      stalls += int'(mem_stall);
      if (dif.data_read !== r || dif.data_write !== w || dif.data_addr !== o_addr ||
          dif.data_mbe !== o_mbe || dif.data_wdata !== o_wdata)
        hold_ok = 1'b0;
    end
    tick();
    dif.data_resp  = 1'b0;
    dif.data_rdata = 32'h0;
    #1;
  endtask

  int          st;
  logic [31:0] oa, ow, ld_prev;
  logic [3:0]  om, orm;
  logic        hold;
  int          nreads;

  initial begin
    rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0; ext_stall = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    dif.data_resp = 1'b0; dif.data_rdata = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_data_read", 32'(dif.data_read), 32'd0);
    chk("rst_data_write", 32'(dif.data_write), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_mbe", 32'(dif.data_mbe), 32'd0);
    chk("rst_rmask", 32'(mem_rmask), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, st, oa, om, ow, orm, hold);
    chk("lw_addr", oa, 32'h100);
    chk("lw_mbe", 32'(om), 32'hF);
    chk("lw_rmask", 32'(orm), 32'hF);
    chk("lw_stall_cycles", 32'(st), 32'd3);
    chk("lw_hold", 32'(hold), 32'd1);
    chk("lw_done_read", 32'(dif.data_read), 32'd0);
    chk("lw_done_stall", 32'(mem_stall), 32'd0);
    chk("lw_load_data", load_data, 32'hDEADBEEF);
    req_read = 1'b0; tick();

    access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1, st, oa, om, ow, orm, hold);
    chk("lb_mbe", 32'(om), 32'h8);
    chk("lb_stall_cycles", 32'(st), 32'd2);
    chk("lb_load_data", load_data, 32'hFFFFFF80);
    req_read = 1'b0; tick();

    access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, st, oa, om, ow, orm, hold);
    chk("lbu_load_data", load_data, 32'h00000080);
    req_read = 1'b0; tick();

    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 1, st, oa, om, ow, orm, hold);
    chk("lh_mbe", 32'(om), 32'hC);
    chk("lh_load_data", load_data, 32'hFFFF80FF);
    req_read = 1'b0; tick();

    access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1, st, oa, om, ow, orm, hold);
    chk("lhu_load_data", load_data, 32'h000080FF);
    req_read = 1'b0; tick();

    ld_prev = load_data;
    access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, st, oa, om, ow, orm, hold);
    chk("sh_addr", oa, 32'h200);
    chk("sh_mbe", 32'(om), 32'hC);
    chk("sh_wdata", ow, 32'hABCD0000);
    chk("sh_rmask", 32'(orm), 32'h0);
    chk("sh_hold", 32'(hold), 32'd1);
    chk("sh_load_unchanged", load_data, ld_prev);
    req_write = 1'b0; tick();

    req_read = 1'b1; funct3 = 3'b010; addr = 32'h101;
    #1;
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_no_read", 32'(dif.data_read), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    req_read = 1'b0; tick();
    chk("mis_pulse_end", 32'(misalign), 32'd0);

    req_read = 1'b1; funct3 = 3'b011; addr = 32'h100;
    #1;
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_no_read", 32'(dif.data_read), 32'd0);
    chk("ill_stall", 32'(mem_stall), 32'd0);
    req_read = 1'b0; tick();

    req_write = 1'b1; funct3 = 3'b100; addr = 32'h100;
    #1;
    chk("ill_store_f3", 32'(illegal), 32'd1);
    chk("ill_store_no_write", 32'(dif.data_write), 32'd0);
    req_write = 1'b0; tick();

    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 1, st, oa, om, ow, orm, hold);
    ext_stall = 1'b1;
    nreads = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dif.data_read === 1'b1) nreads++;
      if (load_data !== 32'h12345678) nreads += 100;
      tick();
    end
    chk("ext_no_reissue", 32'(nreads), 32'd0);
    chk("ext_load_held", load_data, 32'h12345678);
    chk("ext_done_stall", 32'(mem_stall), 32'd0);
    ext_stall = 1'b0; req_read = 1'b0;
    tick();
    chk("ext_idle_read", 32'(dif.data_read), 32'd0);

    req_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    #1;
    chk("to_issue", 32'(dif.data_read), 32'd1);
    repeat (8) tick();
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_still_busy", 32'(mem_stall), 32'd1);
    chk("to_still_read", 32'(dif.data_read), 32'd1);
    rst_n = 1'b0; req_read = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("to_rst_clear", 32'(timeout_err), 32'd0);
    chk("to_rst_read", 32'(dif.data_read), 32'd0);
    chk("to_rst_stall", 32'(mem_stall), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
